// File: rtl/redmule_castin_unpacker.sv
// Holds one packed streamer beat and replays it as RATIO zero-extended sub-beats for the cast stage,
// or forwards it unchanged when cast is off. Optional stall counter: REDMULE_UNPACK_STALL_CNT_EN.
module redmule_castin_unpacker #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned DST_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              cast_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o
`ifdef REDMULE_UNPACK_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int unsigned RATIO = DST_W / ELEM_W;
  localparam int unsigned SUB_W = DATA_W / RATIO;
  localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cast_q, cast_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              held_s;
  logic              final_sub_s;
  logic              accept_s;
  logic              out_hs_s;
  logic [SUB_W-1:0]  payload_s;

  assign held_s      = (state_q == HOLD);
  assign final_sub_s = !cast_q || (cnt_q == CNT_LAST);
  // The held beat can be replaced in the same cycle its last sub-beat leaves: no bubble.
  assign in_ready_o  = !held_s || (out_ready_i && final_sub_s);
  assign accept_s    = in_valid_i && in_ready_o;
  assign out_hs_s    = held_s && out_ready_i;

  // Next-state logic; clear beats a simultaneous accept, accept beats the final handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cast_d  = cast_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = EMPTY;
      data_d  = '0;
      cast_d  = 1'b0;
      last_d  = 1'b0;
      cnt_d   = '0;
    end else if (accept_s) begin
      state_d = HOLD;
      data_d  = in_data_i;
      cast_d  = cast_i;
      last_d  = in_last_i;
      cnt_d   = '0;
    end else if (out_hs_s) begin
      if (final_sub_s) begin
        state_d = EMPTY;
        cnt_d   = '0;
      end else begin
        state_d = HOLD;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cast_q  <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cast_q  <= cast_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sub-beat slice selection, lowest slice first.
  always_comb begin
    payload_s = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        payload_s = data_q[i*SUB_W +: SUB_W];
      end else begin
        payload_s = payload_s;
      end
    end
  end

  // Output data: zero-extended slice when casting, full beat otherwise.
  always_comb begin
    out_data_o = '0;
    if (cast_q) begin
      out_data_o[SUB_W-1:0] = payload_s;
    end else begin
      out_data_o = data_q;
    end
  end

  assign out_valid_o = held_s;
  assign busy_o      = held_s;
  assign out_last_o  = held_s && last_q && final_sub_s;

`ifdef REDMULE_UNPACK_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of back-pressured output cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clear_i) begin
      stall_cnt_d = 32'd0;
    end else if (held_s && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
